// File: rtl/tone_arbiter.sv
// Round-robin arbiter that grants one of three requesters exclusive use of a
// shared tone generator, timing a tone followed by a silent gap in milliseconds.
module tone_arbiter #(
  parameter int unsigned GAP_MS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  ticks_per_milli,
  input  logic [2:0]  req,
  input  logic [29:0] req_freq,
  input  logic [29:0] req_dur,
  input  logic        abort,
  output logic [2:0]  ack,
  output logic [2:0]  done,
  output logic [9:0]  freq,
  output logic        busy,
  output logic [1:0]  grant_id
);

  localparam int unsigned N_REQ = 3;
  localparam int unsigned CW    = 10;
  localparam int unsigned PW    = 6;
  localparam int unsigned GW    = 2;

  localparam logic [CW-1:0] GAP_LEN = CW'(GAP_MS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TONE = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [CW-1:0]    freq_q, freq_d;
  logic             busy_q, busy_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    last_grant_q, last_grant_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CW-1:0]    ms_q, ms_d;
  logic [CW-1:0]    dur_q, dur_d;

  logic [PW-1:0]    tpm_eff;
  logic             ms_tick;
  logic [CW-1:0]    ms_inc;
  logic [CW-1:0]    rf [N_REQ];
  logic [CW-1:0]    rd [N_REQ];
  logic [GW-1:0]    start;
  logic [GW-1:0]    win;
  logic [2:0]       cand;
  logic             found;

  // A programmed rate of zero behaves as one cycle per millisecond.
  assign tpm_eff = (ticks_per_milli == '0) ? PW'(1) : ticks_per_milli;
  assign ms_tick = (presc_q >= (tpm_eff - PW'(1)));
  assign ms_inc  = ms_q + CW'(1);

  // Round-robin search starting just after the last owner.
  always_comb begin : arbitrate
    for (int i = 0; i < N_REQ; i++) begin
      rf[i] = req_freq[CW*i +: CW];
      rd[i] = req_dur[CW*i +: CW];
    end
    start = (last_grant_q == 2'd2) ? 2'd0 : (last_grant_q + 2'd1);
    win   = start;
    found = 1'b0;
    cand  = 3'd0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, start} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!found && req[cand[1:0]]) begin
        found = 1'b1;
        win   = cand[1:0];
      end
    end
  end

  always_comb begin : next_state
    state_d      = state_q;
    ack_d        = '0;
    done_d       = '0;
    freq_d       = freq_q;
    busy_d       = busy_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    presc_d      = presc_q;
    ms_d         = ms_q;
    dur_d        = dur_q;

    if ((state_q != S_IDLE) && abort) begin
      state_d      = S_IDLE;
      freq_d       = '0;
      busy_d       = 1'b0;
      last_grant_d = grant_q;
      presc_d      = '0;
      ms_d         = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          freq_d = '0;
          busy_d = 1'b0;
          if (!abort && found) begin
            ack_d[win] = 1'b1;
            grant_d    = win;
            busy_d     = 1'b1;
            presc_d    = '0;
            ms_d       = '0;
            dur_d      = rd[win];
            // Zero-length tones skip straight to the gap and stay silent.
            if (rd[win] == '0) begin
              state_d = S_GAP;
            end else begin
              state_d = S_TONE;
              freq_d  = rf[win];
            end
          end
        end
        S_TONE: begin
          if (ms_tick) begin
            presc_d = '0;
            if (ms_inc == dur_q) begin
              state_d = S_GAP;
              freq_d  = '0;
              ms_d    = '0;
            end else begin
              ms_d = ms_inc;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        S_GAP: begin
          if ((GAP_LEN == '0) || (ms_tick && (ms_inc == GAP_LEN))) begin
            state_d         = S_IDLE;
            done_d[grant_q] = 1'b1;
            last_grant_d    = grant_q;
            busy_d          = 1'b0;
            presc_d         = '0;
            ms_d            = '0;
          end else if (ms_tick) begin
            presc_d = '0;
            ms_d    = ms_inc;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          freq_d  = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin : regs
    if (rst) begin
      state_q      <= S_IDLE;
      ack_q        <= '0;
      done_q       <= '0;
      freq_q       <= '0;
      busy_q       <= 1'b0;
      grant_q      <= '0;
      last_grant_q <= 2'd2;
      presc_q      <= '0;
      ms_q         <= '0;
      dur_q        <= '0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      freq_q       <= freq_d;
      busy_q       <= busy_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      presc_q      <= presc_d;
      ms_q         <= ms_d;
      dur_q        <= dur_d;
    end
  end

  assign ack      = ack_q;
  assign done     = done_q;
  assign freq     = freq_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_tone_arbiter.sv
// Bench for tone_arbiter: three instances (gap 2, 10, 0 ms) share stimulus;
// a scoreboard monitor checks each grant's timing on the selected instance.
module tb_tone_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  tpm;
  logic [2:0]  req;
  logic [29:0] rfreq;
  logic [29:0] rdur;
  logic        abort;

  logic [2:0] ack_a, ack_b, ack_c, done_a, done_b, done_c;
  logic [9:0] freq_a, freq_b, freq_c;
  logic       busy_a, busy_b, busy_c;
  logic [1:0] gid_a, gid_b, gid_c;

  int         sel;
  logic [2:0] o_ack, o_done;
  logic [9:0] o_freq;
  logic       o_busy;
  logic [1:0] o_gid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tone_arbiter #(.GAP_MS(2)) u_a (
    .clk(clk), .rst(rst), .ticks_per_milli(tpm), .req(req), .req_freq(rfreq),
    .req_dur(rdur), .abort(abort), .ack(ack_a), .done(done_a), .freq(freq_a),
    .busy(busy_a), .grant_id(gid_a));
  tone_arbiter #(.GAP_MS(10)) u_b (
    .clk(clk), .rst(rst), .ticks_per_milli(tpm), .req(req), .req_freq(rfreq),
    .req_dur(rdur), .abort(abort), .ack(ack_b), .done(done_b), .freq(freq_b),
    .busy(busy_b), .grant_id(gid_b));
  tone_arbiter #(.GAP_MS(0)) u_c (
    .clk(clk), .rst(rst), .ticks_per_milli(tpm), .req(req), .req_freq(rfreq),
    .req_dur(rdur), .abort(abort), .ack(ack_c), .done(done_c), .freq(freq_c),
    .busy(busy_c), .grant_id(gid_c));

  always_comb begin
    case (sel)
      1: begin o_ack = ack_b; o_done = done_b; o_freq = freq_b; o_busy = busy_b; o_gid = gid_b; end
      2: begin o_ack = ack_c; o_done = done_c; o_freq = freq_c; o_busy = busy_c; o_gid = gid_c; end
      default: begin o_ack = ack_a; o_done = done_a; o_freq = freq_a; o_busy = busy_a; o_gid = gid_a; end
    endcase
  end

  typedef struct {
    logic [1:0] id;
    logic [9:0] f;
    int         busy_len;
    int         sound_len;
    bit         no_done;
  } exp_t;

  typedef struct {
    int         sel;
    logic [5:0] tpm;
    logic [1:0] id;
    logic [9:0] f;
    logic [9:0] dur;
    int         abort_at;
    int         exp_busy;
    int         exp_sound;
  } vec_t;

  exp_t expq[$];

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Scoreboard: each observed ack pops the next expected transaction.
  int   m_st = 0;
  int   m_busy, m_sound, m_badf;
  exp_t cur;
  always @(negedge clk) begin
    if (m_st == 0) begin
      if (o_ack != 3'd0) begin
        if (expq.size() == 0) begin
          chk("unexpected_ack", int'(o_ack), 0);
        end else begin
          cur = expq.pop_front();
          chk("ack_id", int'(o_ack), 1 << cur.id);
          chk("grant_id", int'(o_gid), int'(cur.id));
          chk("busy_at_ack", int'(o_busy), 1);
          m_busy  = 1;
          m_sound = (o_freq != 10'd0) ? 1 : 0;
          m_badf  = (o_freq != 10'd0 && o_freq != cur.f) ? 1 : 0;
          m_st    = 1;
        end
      end else if (o_done != 3'd0) begin
        chk("stray_done", int'(o_done), 0);
      end
    end else begin
      if (o_busy) begin
        m_busy++;
        if (o_freq != 10'd0) begin
          m_sound++;
          if (o_freq != cur.f) m_badf++;
        end
        if (o_ack != 3'd0) chk("ack_while_busy", int'(o_ack), 0);
      end else begin
        chk("busy_len", m_busy, cur.busy_len);
        chk("sound_len", m_sound, cur.sound_len);
        chk("wrong_freq_cycles", m_badf, 0);
        chk("freq_after", int'(o_freq), 0);
        chk("done_pulse", int'(o_done), cur.no_done ? 0 : (1 << cur.id));
        m_st = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy_a || busy_b || busy_c) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) fail("idle_timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ack(output bit ok);
    int n = 0;
    while (o_ack == 3'd0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = (o_ack != 3'd0);
    if (!ok) begin
      fail("ack_timeout");
      expq.delete();
    end
  endtask

  task automatic set_req(input logic [1:0] id, input logic [9:0] f, input logic [9:0] d);
    rfreq[10*int'(id) +: 10] = f;
    rdur[10*int'(id) +: 10]  = d;
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [9:0] f, input int bl,
                          input int sl, input bit nd);
    exp_t e;
    e.id = id; e.f = f; e.busy_len = bl; e.sound_len = sl; e.no_done = nd;
    expq.push_back(e);
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    wait_idle();
    sel = v.sel;
    tpm = v.tpm;
    set_req(v.id, v.f, v.dur);
    push_exp(v.id, v.f, v.exp_busy, v.exp_sound, v.abort_at > 0);
    req = 3'b001 << v.id;
    wait_ack(ok);
    req = 3'b000;
    if (ok && v.abort_at > 0) begin
      repeat (v.abort_at - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    wait_idle();
  endtask

  vec_t vt[8];

  initial begin
    bit ok;
    int prev;
    // sel 0: gap 2 ms, sel 1: gap 10 ms, sel 2: gap 0 ms
    vt[0] = '{0, 6'd4, 2'd1, 10'd262,  10'd3,  0, 20, 12};
    vt[1] = '{1, 6'd4, 2'd2, 10'd500,  10'd0,  0, 40, 0};
    vt[2] = '{2, 6'd0, 2'd0, 10'd100,  10'd2,  0, 3,  2};
    vt[3] = '{0, 6'd3, 2'd0, 10'd0,    10'd2,  0, 12, 0};
    vt[4] = '{0, 6'd1, 2'd2, 10'd1023, 10'd5,  0, 7,  5};
    vt[5] = '{2, 6'd2, 2'd1, 10'd7,    10'd0,  0, 1,  0};
    vt[6] = '{0, 6'd2, 2'd0, 10'd55,   10'd1,  0, 6,  2};
    vt[7] = '{0, 6'd4, 2'd1, 10'd784,  10'd10, 5, 5,  5};

    sel = 0; rst = 1'b1; tpm = 6'd1; req = 3'b000; abort = 1'b0;
    rfreq = '0; rdur = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", int'(ack_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_freq", int'(freq_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_grant", int'(gid_a), 0);
    rst = 1'b0;
    @(negedge clk);

    // All three requesting continuously: order 0,1,2,0 with one idle cycle.
    rfreq = {10'd33, 10'd22, 10'd11};
    rdur  = {10'd1, 10'd1, 10'd1};
    push_exp(2'd0, 10'd11, 3, 1, 1'b0);
    push_exp(2'd1, 10'd22, 3, 1, 1'b0);
    push_exp(2'd2, 10'd33, 3, 1, 1'b0);
    push_exp(2'd0, 10'd11, 3, 1, 1'b0);
    req  = 3'b111;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ack(ok);
      if (!ok) break;
      if (k == 3) req = 3'b000;
      if (k > 0) chk("rr_spacing", cyc - prev, 4);
      prev = cyc;
      @(negedge clk);
    end
    req = 3'b000;
    wait_idle();

    for (int i = 0; i < 8; i++) run_vec(vt[i]);

    // Owner 1 was aborted, so the next search starts at requester 2.
    sel = 0; tpm = 6'd1;
    set_req(2'd2, 10'd300, 10'd1);
    set_req(2'd0, 10'd301, 10'd1);
    set_req(2'd1, 10'd302, 10'd1);
    push_exp(2'd2, 10'd300, 3, 1, 1'b0);
    req = 3'b111;
    wait_ack(ok);
    req = 3'b000;
    wait_idle();

    // Abort while idle blocks arbitration for that cycle only.
    set_req(2'd1, 10'd77, 10'd1);
    push_exp(2'd1, 10'd77, 3, 1, 1'b0);
    req = 3'b010; abort = 1'b1;
    @(negedge clk);
    chk("abort_idle_ack", int'(ack_a), 0);
    abort = 1'b0;
    @(negedge clk);
    chk("ack_after_abort", int'(ack_a), 2);
    req = 3'b000;
    wait_idle();

    // Reset in the middle of a tone, then requester 0 wins first.
    tpm = 6'd4;
    set_req(2'd0, 10'd440, 10'd5);
    push_exp(2'd0, 10'd440, 4, 4, 1'b1);
    req = 3'b001;
    wait_ack(ok);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    req = 3'b111;
    @(negedge clk);
    chk("midrst_freq", int'(freq_a), 0);
    chk("midrst_busy", int'(busy_a), 0);
    chk("midrst_grant", int'(gid_a), 0);
    chk("midrst_done", int'(done_a), 0);
    @(negedge clk);
    push_exp(2'd0, 10'd440, 28, 20, 1'b0);
    rst = 1'b0;
    wait_ack(ok);
    req = 3'b000;
    wait_idle();

    chk("queue_empty", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
